pong_match_ctrl: RTL
====================

// Module: pong_match_ctrl
// PURPOSE
//  Parametrised match referee for the pong game; next generation of the serve/play/end state machine.
//  Watches ball_x against both board lines and the match timer, keeps both scores, and holds the
//  game for a fixed number of cycles after each point. Chooses the server by a configurable rule and
//  reports the winner, including a draw on timeout. Feeds ball/paddle logic and the score display.
// PARAMETERS
//  SCORE_W      4    score register width
//  GOAL_POINTS  7    points needed to win (1 .. 2^SCORE_W-1)
//  X_W          10   ball_x width
//  P1_BOARD_X   110  ball_x < this  -> point to P2
//  P2_BOARD_X   530  ball_x > this  -> point to P1
//  TIME_W       6    time_cnt width
//  HOLD_CYCLES  50   cycles spent in POINT_HOLD (>=1)
//  SERVE_MODE   0    0: player who conceded serves; 1: serve swaps every 2 total points, P1 first
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-low reset
//  p1u,p1d      in   1 each   P1 buttons, active-low
//  p2u,p2d      in   1 each   P2 buttons, active-low
//  ball_x       in   X_W      ball horizontal position
//  time_cnt     in   TIME_W   remaining match time, 0 = expired
//  game_state   out  3        0 P1_SERVE, 1 P2_SERVE, 2 PLAYING, 3 POINT_HOLD, 4 GAME_END
//  p1_score     out  SCORE_W  P1 points
//  p2_score     out  SCORE_W  P2 points
//  winner       out  2        0 none, 1 P1, 2 P2, 3 draw
//  point_pulse  out  1        one-cycle pulse in the cycle a point is scored
// BEHAVIOUR
//  - All outputs registered. Reset: game_state=P1_SERVE, scores=0, winner=0, point_pulse=0,
//    hold counter=0, total-point counter=0. Reset mid-match aborts immediately.
//  - P1_SERVE: !p1u|!p1d -> PLAYING next cycle. P2_SERVE: same with p2 buttons. Other player ignored.
//  - In either serve state, time_cnt==0 -> GAME_END (takes priority over a button press).
//  - PLAYING, priority order: ball_x>P2_BOARD_X -> p1_score+1; else ball_x<P1_BOARD_X -> p2_score+1;
//    else time_cnt==0 -> GAME_END; else stay. A point sets point_pulse=1 for that cycle, loads the
//    hold counter with HOLD_CYCLES-1, increments total points, and goes to POINT_HOLD.
//    A point taken in the same cycle that time_cnt reaches 0 is counted; the timeout then applies at
//    hold exit.
//  - Scores saturate at 2^SCORE_W-1; the total counter is SCORE_W+1 bits wide and also saturates.
//  - POINT_HOLD: buttons ignored; counter decrements each cycle; exit when counter==0, so state is
//    held for exactly HOLD_CYCLES cycles. At exit, using the updated scores:
//      win condition met -> GAME_END; else time_cnt==0 -> GAME_END; else -> server's serve state.
//  - Server: SERVE_MODE 0 -> conceding player (P1 scored -> P2_SERVE). SERVE_MODE 1 -> P2_SERVE when
//    bit1 of total points is 1, else P1_SERVE.
//  - Win condition: score>=GOAL_POINTS (refined by macro below). Both can never win at once.
//  - winner is set on entry to GAME_END: win -> scoring player; timeout -> higher score, 3 if equal.
//  - GAME_END is sticky until reset; scores and winner frozen, point_pulse=0.
// CONFIGURATION
//  PONG_DEUCE_EN defined: win needs score>=GOAL_POINTS AND lead>=2 (deuce). A player reaching
//    saturation (2^SCORE_W-1) wins outright regardless of lead.
//  Not defined: first to GOAL_POINTS wins, no margin check.
// TESTING (GOAL_POINTS=3, HOLD_CYCLES=4, SERVE_MODE=0 unless stated)
//  1 Reset low mid-PLAYING with scores 2/1 -> next edge: state 0, scores 0/0, winner 0, pulse 0.
//  2 P1_SERVE, p1u=0 -> PLAYING; ball_x=600 -> pulse 1 cycle, p1=1, 4 cycles POINT_HOLD, then P2_SERVE.
//  3 Three P1 points, no deuce -> after the 3rd hold, GAME_END, winner=1; buttons ignored thereafter.
//  4 PONG_DEUCE_EN, scores 2/2, P1 scores -> 3/2 back to serve; P1 scores again -> 4/2 GAME_END, winner=1.
//  5 PLAYING, 1/1, time_cnt->0, ball_x=300 -> GAME_END next cycle, winner=3; with 2/1 -> winner=1.
//  6 SERVE_MODE=1, after totals 1,2,3,4 -> serves P1,P2,P2,P1; ball_x=100 in P1_SERVE -> no score.

Source files
------------

// File: rtl/pong_match_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl_if
// Bundles the referee's inputs and its results for the ball/paddle logic and
// the score display.
//   p1u, p1d, p2u, p2d : player buttons, active-low
//   ball_x             : ball horizontal position
//   time_cnt           : remaining match time, 0 = expired
//   game_state         : 0 P1_SERVE, 1 P2_SERVE, 2 PLAYING, 3 POINT_HOLD, 4 GAME_END
//   p1_score, p2_score : current points
//   winner             : 0 none, 1 P1, 2 P2, 3 draw
//   point_pulse        : one-cycle strobe in the cycle a point is scored
// Modports: master drives the inputs and reads the results; slave is the
// referee itself.
// ---------------------------------------------------------------------------
interface pong_match_ctrl_if #(
  parameter int X_W     = 10,
  parameter int TIME_W  = 6,
  parameter int SCORE_W = 4
);
  logic               p1u;
  logic               p1d;
  logic               p2u;
  logic               p2d;
  logic [X_W-1:0]     ball_x;
  logic [TIME_W-1:0]  time_cnt;
  logic [2:0]         game_state;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic               point_pulse;

  modport master (
    output p1u, p1d, p2u, p2d, ball_x, time_cnt,
    input  game_state, p1_score, p2_score, winner, point_pulse
  );

  modport slave (
    input  p1u, p1d, p2u, p2d, ball_x, time_cnt,
    output game_state, p1_score, p2_score, winner, point_pulse
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
// Match referee for the pong game. It watches ball_x against both board
// lines and the match timer, keeps both scores, and holds play for
// HOLD_CYCLES cycles after each point. It then picks the next server and
// reports the winner, or a draw on timeout.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : pong_match_ctrl_if.slave. It carries the buttons, ball_x and
//            time_cnt in, and the game_state, scores, winner and
//            point_pulse out. All outputs are registered.
// Configuration macro:
//   PONG_DEUCE_EN : when defined, a win needs score >= GOAL_POINTS and a
//                   lead of at least 2. A player whose score has saturated
//                   wins outright. When undefined, the first player to reach
//                   GOAL_POINTS wins.
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int GOAL_POINTS = 7,
  parameter int X_W         = 10,
  parameter int P1_BOARD_X  = 110,
  parameter int P2_BOARD_X  = 530,
  parameter int TIME_W      = 6,
  parameter int HOLD_CYCLES = 50,
  parameter int SERVE_MODE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  pong_match_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    P1_SERVE   = 3'd0,
    P2_SERVE   = 3'd1,
    PLAYING    = 3'd2,
    POINT_HOLD = 3'd3,
    GAME_END   = 3'd4
  } state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
  localparam logic [SCORE_W:0]     TOTAL_MAX = '1;
  localparam logic [SCORE_W+1:0]   GOAL_EXT  = (SCORE_W+2)'(GOAL_POINTS);
  localparam logic [X_W-1:0]       P1_LINE   = X_W'(P1_BOARD_X);
  localparam logic [X_W-1:0]       P2_LINE   = X_W'(P2_BOARD_X);

  state_t             state;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic               point_pulse;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SCORE_W:0]   total_pts;
  logic               last_p1_scored;

  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;
  logic [SCORE_W:0]   total_inc;
  logic [SCORE_W+1:0] p1_ext;
  logic [SCORE_W+1:0] p2_ext;
  logic               p1_wins;
  logic               p2_wins;
  logic [1:0]         timeout_winner;
  logic               time_up;
  state_t             next_server;

  // Saturating increments for the scores and the total-point counter.
  assign p1_inc    = (p1_score == SCORE_MAX) ? p1_score : p1_score + 1'b1;
  assign p2_inc    = (p2_score == SCORE_MAX) ? p2_score : p2_score + 1'b1;
  assign total_inc = (total_pts == TOTAL_MAX) ? total_pts : total_pts + 1'b1;

  assign p1_ext  = {2'b00, p1_score};
  assign p2_ext  = {2'b00, p2_score};
  assign time_up = (bus.time_cnt == '0);

  // The win check is only evaluated at hold exit, after the point has been
  // added. The two conditions can never both be true.
`ifdef PONG_DEUCE_EN
  localparam logic [SCORE_W+1:0] LEAD_MIN = (SCORE_W+2)'(2);
  assign p1_wins = ((p1_ext >= GOAL_EXT) && (p1_ext >= p2_ext + LEAD_MIN)) ||
                   (p1_score == SCORE_MAX);
  assign p2_wins = ((p2_ext >= GOAL_EXT) && (p2_ext >= p1_ext + LEAD_MIN)) ||
                   (p2_score == SCORE_MAX);
`else
  assign p1_wins = (p1_ext >= GOAL_EXT);
  assign p2_wins = (p2_ext >= GOAL_EXT);
`endif

  // On timeout the higher score wins. Equal scores are a draw (3).
  assign timeout_winner = (p1_score > p2_score) ? 2'd1 :
                          (p2_score > p1_score) ? 2'd2 : 2'd3;

  // Mode 0: the player who conceded the last point serves.
  // Mode 1: the serve swaps every two total points, with P1 serving first.
  assign next_server = (SERVE_MODE == 0) ?
                         (last_p1_scored ? P2_SERVE : P1_SERVE) :
                         (total_pts[1]   ? P2_SERVE : P1_SERVE);

  // Referee state machine. The state, scores, winner and point strobe are
  // all registers, so every output is glitch-free. GAME_END keeps
  // everything frozen until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= P1_SERVE;
      p1_score       <= '0;
      p2_score       <= '0;
      winner         <= 2'd0;
      point_pulse    <= 1'b0;
      hold_cnt       <= '0;
      total_pts      <= '0;
      last_p1_scored <= 1'b0;
    end else begin
      point_pulse <= 1'b0;
      case (state)
        P1_SERVE: begin
          if (time_up) begin
            state  <= GAME_END;
            winner <= timeout_winner;
          end else if (!bus.p1u || !bus.p1d) begin
            state <= PLAYING;
          end
        end
        P2_SERVE: begin
          if (time_up) begin
            state  <= GAME_END;
            winner <= timeout_winner;
          end else if (!bus.p2u || !bus.p2d) begin
            state <= PLAYING;
          end
        end
        PLAYING: begin
          // A point scored in the same cycle that the timer expires still
          // counts. The timeout is then applied when the hold ends.
          if (bus.ball_x > P2_LINE) begin
            p1_score       <= p1_inc;
            last_p1_scored <= 1'b1;
            point_pulse    <= 1'b1;
            hold_cnt       <= HOLD_LOAD;
            total_pts      <= total_inc;
            state          <= POINT_HOLD;
          end else if (bus.ball_x < P1_LINE) begin
            p2_score       <= p2_inc;
            last_p1_scored <= 1'b0;
            point_pulse    <= 1'b1;
            hold_cnt       <= HOLD_LOAD;
            total_pts      <= total_inc;
            state          <= POINT_HOLD;
          end else if (time_up) begin
            state  <= GAME_END;
            winner <= timeout_winner;
          end
        end
        POINT_HOLD: begin
          // The counter is loaded with HOLD_CYCLES-1 and play leaves on the
          // cycle it reads zero, so the hold lasts exactly HOLD_CYCLES cycles.
          if (hold_cnt == '0) begin
            if (p1_wins) begin
              state  <= GAME_END;
              winner <= 2'd1;
            end else if (p2_wins) begin
              state  <= GAME_END;
              winner <= 2'd2;
            end else if (time_up) begin
              state  <= GAME_END;
              winner <= timeout_winner;
            end else begin
              state <= next_server;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        GAME_END: begin
        end
        default: begin
          state <= P1_SERVE;
        end
      endcase
    end
  end

  assign bus.game_state  = state;
  assign bus.p1_score    = p1_score;
  assign bus.p2_score    = p2_score;
  assign bus.winner      = winner;
  assign bus.point_pulse = point_pulse;

endmodule
